// File: rtl/alu_cmd_queue_if.sv
// rtl/alu_cmd_queue_if.sv - producer/consumer handshake bundle for the ALU command queue
interface alu_cmd_queue_if #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 3,
    parameter int D_W   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_op;
    logic [D_W-1:0]   in_a;
    logic [D_W-1:0]   in_b;
    logic             out_valid;
    logic             out_ready;
    logic [OP_W-1:0]  out_op;
    logic [D_W-1:0]   out_a;
    logic [D_W-1:0]   out_b;
    logic [CNT_W-1:0] count;
    logic             ovf;

    // Queue side: accepts commands, presents the head, reports status
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_op, out_a, out_b, count, ovf
    );

    // Environment side: producer plus ALU consumer
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_op, out_a, out_b, count, ovf
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// rtl/alu_cmd_queue.sv - in-order ALU command buffer; ALU_CMD_QUEUE_OVF_EN adds a sticky overflow flag
module alu_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 3,
    parameter int D_W   = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_cmd_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int E_W   = OP_W + 2 * D_W;

    logic [E_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full, empty, push, pop;
    logic [E_W-1:0]   head;

    // in_ready depends only on stored count, so there is no path from out_ready
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = bus.in_valid & ~full;
    assign pop   = ~empty & bus.out_ready;

    // Next-state for pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);
    end

    // Pointer and count registers; reset discards everything queued
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are left stale on reset since count gates visibility
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= {bus.in_op, bus.in_a, bus.in_b};
    end

    assign head          = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.out_op    = head[E_W-1 -: OP_W];
    assign bus.out_a     = head[2*D_W-1 -: D_W];
    assign bus.out_b     = head[D_W-1:0];
    assign bus.out_valid = ~empty;
    assign bus.in_ready  = ~full;
    assign bus.count     = count_q;

`ifdef ALU_CMD_QUEUE_OVF_EN
    logic ovf_q;

    // Sticky record of any offer refused because the queue was full
    always_ff @(posedge clk) begin
        if (rst)                        ovf_q <= 1'b0;
        else if (bus.in_valid && full)  ovf_q <= 1'b1;
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb/tb_alu_cmd_queue.sv - scoreboard bench for alu_cmd_queue
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;
    localparam int OP_W  = 3;
    localparam int D_W   = 4;
    localparam int EXP_POPS = 17;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_cmd_queue_if #(.DEPTH(DEPTH), .OP_W(OP_W), .D_W(D_W)) bus ();

    alu_cmd_queue #(.DEPTH(DEPTH), .OP_W(OP_W), .D_W(D_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int mcount = 0;
    bit movf   = 1'b0;
    bit armed  = 1'b0;
    logic [OP_W+2*D_W-1:0] sb[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare status against the occupancy model and pop the scoreboard on transfers
    always @(negedge clk) begin
        logic [OP_W+2*D_W-1:0] e;
        bit do_pop, do_push;
        if (armed) begin
            check("count", int'(bus.count), mcount);
            check("in_ready", int'(bus.in_ready), (mcount != DEPTH) ? 1 : 0);
            check("out_valid", int'(bus.out_valid), (mcount != 0) ? 1 : 0);
            check("ovf", int'(bus.ovf), int'(movf));
            if (mcount == 0) begin
                check("empty_out_zero", int'({bus.out_op, bus.out_a, bus.out_b}), 0);
            end
        end
        do_pop  = armed && !rst && (mcount != 0) && bus.out_ready;
        do_push = !rst && bus.in_valid && (mcount != DEPTH);
        if (do_pop) begin
            pops++;
            if (sb.size() == 0) begin
                check("scoreboard_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_op", int'(bus.out_op), int'(e[OP_W+2*D_W-1 -: OP_W]));
                check("out_a",  int'(bus.out_a),  int'(e[2*D_W-1 -: D_W]));
                check("out_b",  int'(bus.out_b),  int'(e[D_W-1:0]));
            end
        end
`ifdef ALU_CMD_QUEUE_OVF_EN
        if (!rst && bus.in_valid && mcount == DEPTH) movf = 1'b1;
`endif
        if (rst) begin
            armed  = 1'b1;
            mcount = 0;
            movf   = 1'b0;
            sb.delete();
        end else begin
            if (do_push) sb.push_back({bus.in_op, bus.in_a, bus.in_b});
            mcount = mcount + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
        end
    end

    // One cycle of stimulus; inputs change just after the rising edge
    task automatic cyc(input bit v, input int op, input int a, input int b, input bit r);
        bus.in_valid  = v;
        bus.in_op     = OP_W'(op);
        bus.in_a      = D_W'(a);
        bus.in_b      = D_W'(b);
        bus.out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
        // Reset with an offer present
        rst = 1'b1;
        cyc(1, 0, 7, 7, 1);
        cyc(1, 0, 7, 7, 1);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        // Single pass ADD(5,3)
        cyc(1, 0, 5, 3, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // Fill with out_ready low
        cyc(1, 1, 10, 4, 0);
        cyc(1, 2, 12, 10, 0);
        cyc(1, 3, 12, 10, 0);
        cyc(1, 4, 12, 10, 0);
        cyc(0, 0, 0, 0, 0);
        // Full: NOR offered while SUB pops, then accepted the next cycle
        cyc(1, 5, 12, 10, 1);
        cyc(1, 5, 12, 10, 1);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);
        // Back-to-back push+pop across pointer wrap
        for (int i = 0; i < 10; i++) cyc(1, i % 8, i, 15 - i, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        // Mid-stream reset at count 3
        cyc(1, 6, 1, 2, 0);
        cyc(1, 6, 3, 4, 0);
        cyc(1, 6, 5, 6, 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 7, 0, 10, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        @(negedge clk);
        check("total_pops", pops, EXP_POPS);
        check("scoreboard_left", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
